// File: rtl/shift_pkg.sv
// Shared types and helpers for the multi-cycle shift unit.
package shift_pkg;

    // Operation codes presented on in_op.
    typedef enum logic [1:0] {
        OP_SLL = 2'd0,
        OP_SRL = 2'd1,
        OP_SRA = 2'd2,
        OP_ROL = 2'd3
    } shift_op_t;

    // Control FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Width of the shift-amount field for an operand of w bits (never below 1).
    function automatic int amt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: shifts din by 0..STEP positions.
// Rotate support is compiled in only when SHIFT_UNIT_ROTATE_EN is defined;
// otherwise ROL falls through to the SLL path and no rotate logic exists.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int SW    = $clog2(STEP) + 1
) (
    input  logic [WIDTH-1:0] din,
    input  logic [SW-1:0]    amt,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] cand [0:STEP];

    genvar gi;
    generate
        for (gi = 0; gi <= STEP; gi++) begin : g_cand
            if (gi == 0) begin : g_zero
                assign cand[gi] = din;
            end else begin : g_shift
`ifdef SHIFT_UNIT_ROTATE_EN
                logic [2*WIDTH-1:0] dbl;
                assign dbl = {din, din} << gi;
`endif
                // Candidate result for a fixed shift distance of gi.
                always_comb begin
                    cand[gi] = din << gi;
                    case (shift_op_t'(op))
                        OP_SRL:  cand[gi] = din >> gi;
                        OP_SRA:  cand[gi] = $signed(din) >>> gi;
`ifdef SHIFT_UNIT_ROTATE_EN
                        OP_ROL:  cand[gi] = dbl[2*WIDTH-1:WIDTH];
`endif
                        default: cand[gi] = din << gi;
                    endcase
                end
            end
        end
    endgenerate

    // Pick the candidate matching the requested distance (amt never exceeds STEP).
    always_comb begin
        dout = cand[amt];
    end

endmodule

// File: rtl/shift_unit.sv
// Iterative shifter with valid/ready handshakes on both sides. The operand is
// shifted by up to STEP positions per cycle until the requested amount is used
// up. Optional rotate-left support: define SHIFT_UNIT_ROTATE_EN.
module shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    input  logic [amt_width(WIDTH)-1:0] in_amt,
    input  logic [1:0]                  in_op,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data
);

    localparam int AW = amt_width(WIDTH);
    localparam int SW = $clog2(STEP) + 1;
    // One extra bit so STEP itself is representable even when STEP == WIDTH.
    localparam logic [AW:0] STEP_EXT = (AW+1)'(STEP);

    state_t            state_reg;
    logic [AW-1:0]     remaining_reg;
    logic [WIDTH-1:0]  data_reg;
    shift_op_t         op_reg;
    logic              in_ready_reg;
    logic              out_valid_reg;

    logic [AW:0]       rem_ext;
    logic [SW-1:0]     step_amt;
    logic [AW:0]       rem_next;
    logic [WIDTH-1:0]  step_out;

    // Distance for this cycle is min(STEP, remaining); remaining drops by the same.
    always_comb begin
        rem_ext = {1'b0, remaining_reg};
        if (rem_ext >= STEP_EXT) begin
            step_amt = SW'(STEP);
        end else begin
            step_amt = SW'(rem_ext);
        end
        rem_next = rem_ext - (AW+1)'(step_amt);
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .SW    (SW)
    ) u_step (
        .din   (data_reg),
        .amt   (step_amt),
        .op    (op_reg),
        .dout  (step_out)
    );

    // Control FSM with registered handshake outputs; flush beats everything but reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            remaining_reg <= '0;
            data_reg      <= '0;
            op_reg        <= OP_SLL;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else if (flush) begin
            state_reg     <= ST_IDLE;
            remaining_reg <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_reg      <= in_data;
                        op_reg        <= shift_op_t'(in_op);
                        remaining_reg <= in_amt;
                        in_ready_reg  <= 1'b0;
                        if (in_amt != '0) begin
                            state_reg <= ST_SHIFT;
                        end else begin
                            state_reg     <= ST_DONE;
                            out_valid_reg <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    data_reg      <= step_out;
                    remaining_reg <= rem_next[AW-1:0];
                    if (rem_next == '0) begin
                        state_reg     <= ST_DONE;
                        out_valid_reg <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_reg     <= ST_IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    remaining_reg <= '0;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = data_reg;

endmodule
